// File: rtl/data_memory_responder.sv
// Data-memory responder: word-organised RAM behind a request/ready bus with a shared tristate databus.
// Optional misaligned-access trap enabled by defining DMEM_ALIGN_CHECK_EN.
module data_memory_responder #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Memory_request,
    input  logic [ADDR_W-1:0] Memory_addressbus,
    input  logic              Memory_writemode,
    inout  wire  [DATA_W-1:0] Memory_databus,
    output logic              Memory_ready,
    output logic              Memory_error
);

    localparam int WA_W  = ADDR_W - 1;
    localparam int WORDS = 2 ** WA_W;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        WR_ACK
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [WA_W-1:0]   addr_q, addr_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem [WORDS];

    logic              ram_we;
    logic              ram_re;
    logic [WA_W-1:0]   live_word;
    logic [WA_W-1:0]   ram_raddr;
    logic              misaligned;
    logic              drive_en;

    assign live_word  = Memory_addressbus[ADDR_W-1:1];
    assign misaligned = ALIGN_CHECK & Memory_addressbus[0];
    // With a single-cycle latency the read happens on the acceptance edge, before addr_q is loaded.
    assign ram_raddr  = (state_q == IDLE) ? live_word : addr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        err_d   = err_q;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Memory_request) begin
                    addr_d = live_word;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = WR_ACK;
                    end else if (Memory_writemode) begin
                        ram_we  = 1'b1;
                        state_d = WR_ACK;
                    end else if (READ_LATENCY == 1) begin
                        ram_re  = 1'b1;
                        state_d = RD_DRIVE;
                    end else begin
                        cnt_d   = 2'(READ_LATENCY - 1);
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    ram_re  = 1'b1;
                    state_d = RD_DRIVE;
                end
            end
            RD_DRIVE: begin
                state_d = IDLE;
            end
            WR_ACK: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    // RAM and its output register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[live_word] <= Memory_databus;
        end
        if (ram_re) begin
            rdata_q <= mem[ram_raddr];
        end
    end

    assign Memory_ready = (state_q == RD_DRIVE) || (state_q == WR_ACK);
    assign Memory_error = err_q;

    // Never fight an initiator that has already turned the bus around for a write.
    assign drive_en       = (state_q == RD_DRIVE) && !Memory_writemode;
    assign Memory_databus = drive_en ? rdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: three instances at read latencies 1, 3 and 4.
// While a quiet bus is expected the bench holds 0 on it, so any responder drive shows up as a nonzero value.
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req     [3];
    logic [11:0] addr    [3];
    logic        wm      [3];
    logic        oe      [3];
    logic [15:0] dq      [3];
    logic [15:0] bus_obs [3];
    logic        rdy     [3];
    logic        err     [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int LAT = (gi == 0) ? 1 : (gi == 1) ? 3 : 4;
            wire [15:0] dbus;
            assign dbus = oe[gi] ? dq[gi] : 16'hzzzz;
            assign bus_obs[gi] = dbus;
            data_memory_responder #(
                .ADDR_W      (12),
                .DATA_W      (16),
                .READ_LATENCY(LAT)
            ) u_dut (
                .clk              (clk),
                .rst_n            (rst_n),
                .Memory_request   (req[gi]),
                .Memory_addressbus(addr[gi]),
                .Memory_writemode (wm[gi]),
                .Memory_databus   (dbus),
                .Memory_ready     (rdy[gi]),
                .Memory_error     (err[gi])
            );
        end
    endgenerate

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic do_write(input int i, input logic [11:0] a, input logic [15:0] d, input string tag);
        @(negedge clk);
        req[i] = 1'b1; wm[i] = 1'b1; addr[i] = a; oe[i] = 1'b1; dq[i] = d;
        @(negedge clk);
        check_eq({tag, "_wr_rdy"}, 16'(rdy[i]), 16'h0001);
        check_eq({tag, "_wr_err"}, 16'(err[i]), 16'h0000);
        req[i] = 1'b0; wm[i] = 1'b0; oe[i] = 1'b0;
        @(negedge clk);
        check_eq({tag, "_wr_idle"}, 16'(rdy[i]), 16'h0000);
        $display("write inst%0d addr=%h data=%h", i, a, d);
    endtask

    task automatic do_read(input int i, input logic [11:0] a, input int lat, input logic [15:0] expv,
                           input string tag, input bit change, input logic [11:0] alt);
        @(negedge clk);
        req[i] = 1'b1; wm[i] = 1'b0; addr[i] = a; oe[i] = 1'b1; dq[i] = 16'h0000;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk);
            #1;
            if (change && k == 1) addr[i] = alt;
            if (k == lat) oe[i] = 1'b0;
            @(negedge clk);
            if (k < lat) begin
                check_eq($sformatf("%s_wait%0d_rdy", tag, k), 16'(rdy[i]), 16'h0000);
                check_eq($sformatf("%s_wait%0d_bus", tag, k), bus_obs[i], 16'h0000);
            end else begin
                check_eq({tag, "_rd_rdy"}, 16'(rdy[i]), 16'h0001);
                check_eq({tag, "_rd_data"}, bus_obs[i], expv);
                req[i] = 1'b0;
            end
        end
        @(negedge clk);
        check_eq({tag, "_rd_idle"}, 16'(rdy[i]), 16'h0000);
        $display("read  inst%0d addr=%h data=%h", i, a, bus_obs[i]);
    endtask

    initial begin
        int late_pulses;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; wm[i] = 1'b0; addr[i] = 12'h000; oe[i] = 1'b1; dq[i] = 16'h0000;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("reset_rdy%0d", i), 16'(rdy[i]), 16'h0000);
            check_eq($sformatf("reset_err%0d", i), 16'(err[i]), 16'h0000);
            check_eq($sformatf("reset_bus%0d", i), bus_obs[i], 16'h0000);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) oe[i] = 1'b0;

        // Basic write then read at latency 1.
        do_write(0, 12'h040, 16'hBEEF, "t2");
        do_read (0, 12'h040, 1, 16'hBEEF, "t2", 1'b0, 12'h000);

        // Latency 4: address moved mid-wait must not affect the returned word.
        do_write(2, 12'hFFE, 16'h1234, "t3a");
        do_write(2, 12'h000, 16'h9999, "t3b");
        do_read (2, 12'hFFE, 4, 16'h1234, "t3", 1'b1, 12'h000);
        do_read (2, 12'h000, 4, 16'h9999, "t3z", 1'b0, 12'h000);

        // Request held through ready: one access per pulse, second accepted from IDLE.
        @(negedge clk);
        req[0] = 1'b1; wm[0] = 1'b1; addr[0] = 12'h010; oe[0] = 1'b1; dq[0] = 16'h0001;
        @(negedge clk);
        check_eq("t4_rdy1", 16'(rdy[0]), 16'h0001);
        addr[0] = 12'h012; dq[0] = 16'h0002;
        @(negedge clk);
        check_eq("t4_gap", 16'(rdy[0]), 16'h0000);
        @(negedge clk);
        check_eq("t4_rdy2", 16'(rdy[0]), 16'h0001);
        req[0] = 1'b0; wm[0] = 1'b0; oe[0] = 1'b0;
        @(negedge clk);
        check_eq("t4_idle", 16'(rdy[0]), 16'h0000);
        $display("write inst0 back-to-back 010=0001 012=0002");
        do_read(0, 12'h010, 1, 16'h0001, "t4a", 1'b0, 12'h000);
        do_read(0, 12'h012, 1, 16'h0002, "t4b", 1'b0, 12'h000);

        // Odd address.
`ifdef DMEM_ALIGN_CHECK_EN
        @(negedge clk);
        req[0] = 1'b1; wm[0] = 1'b0; addr[0] = 12'h041; oe[0] = 1'b1; dq[0] = 16'h0000;
        @(negedge clk);
        check_eq("t5_rdy", 16'(rdy[0]), 16'h0001);
        check_eq("t5_err", 16'(err[0]), 16'h0001);
        check_eq("t5_bus", bus_obs[0], 16'h0000);
        req[0] = 1'b0; oe[0] = 1'b0;
        @(negedge clk);
        check_eq("t5_err_clr", 16'(err[0]), 16'h0000);
        do_write(0, 12'h041, 16'h7777, "t5w_dummy_skip") ;
        do_read(0, 12'h040, 1, 16'hBEEF, "t5_unchanged", 1'b0, 12'h000);
`else
        do_read(0, 12'h041, 1, 16'hBEEF, "t5", 1'b0, 12'h000);
        check_eq("t5_err", 16'(err[0]), 16'h0000);
`endif

        // Initiator turns the bus around during the drive cycle.
        @(negedge clk);
        req[0] = 1'b1; wm[0] = 1'b0; addr[0] = 12'h040; oe[0] = 1'b0;
        @(posedge clk);
        #1;
        wm[0] = 1'b1; oe[0] = 1'b1; dq[0] = 16'h5555;
        @(negedge clk);
        check_eq("t6_rdy", 16'(rdy[0]), 16'h0001);
        check_eq("t6_bus", bus_obs[0], 16'h5555);
        req[0] = 1'b0; wm[0] = 1'b0; oe[0] = 1'b0;
        @(negedge clk);
        check_eq("t6_idle", 16'(rdy[0]), 16'h0000);
        $display("read  inst0 addr=040 with writemode raised, bus=5555 kept");

        // Reset in the middle of a latency-3 read.
        do_write(1, 12'h020, 16'h00AA, "t1w");
        do_read (1, 12'h020, 3, 16'h00AA, "t1r", 1'b0, 12'h000);
        @(negedge clk);
        req[1] = 1'b1; wm[1] = 1'b0; addr[1] = 12'h020; oe[1] = 1'b1; dq[1] = 16'h0000;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t1_rst_rdy", 16'(rdy[1]), 16'h0000);
        check_eq("t1_rst_bus", bus_obs[1], 16'h0000);
        req[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        late_pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rdy[1] || bus_obs[1] != 16'h0000) late_pulses++;
        end
        check_eq("t1_no_late_rdy", 16'(late_pulses), 16'h0000);
        oe[1] = 1'b0;
        $display("reset during read inst1, dropped");
        do_read(1, 12'h020, 3, 16'h00AA, "t1_kept", 1'b0, 12'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
